// File: rtl/pulse_burst_sequencer.sv
// Programmable pulse-train engine: bursts of square pulses separated by idle gaps.
// Optional PBS_CONTINUOUS_EN: bursts=0 runs unlimited bursts until abort/reset.
module pulse_burst_sequencer #(
  parameter int CNTW = 32,
  parameter int PULW = 16,
  parameter int BRSW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [CNTW-1:0] half_period,
  input  logic [PULW-1:0] pulses,
  input  logic [BRSW-1:0] bursts,
  input  logic [CNTW-1:0] gap,
  output logic            pulse_out,
  output logic            busy,
  output logic            burst_done,
  output logic            done,
  output logic [PULW-1:0] pulse_count
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t          state;
  logic [CNTW-1:0] h_m1;
  logic [CNTW-1:0] cfg_gap;
  logic [PULW-1:0] cfg_pulses;
  logic            unlimited;
  logic [CNTW-1:0] cnt;
  logic [PULW-1:0] pls_left;
  logic [BRSW-1:0] brs_left;

  logic [CNTW-1:0] hp_m1;
  logic            zero_cfg;
  logic            unlim_req;

  // A half-period of 0 behaves like 1, so the phase counter reload is max(hp,1)-1.
  assign hp_m1 = (half_period == '0) ? '0 : half_period - CNTW'(1);

`ifdef PBS_CONTINUOUS_EN
  assign zero_cfg  = (pulses == '0);
  assign unlim_req = (bursts == '0);
`else
  assign zero_cfg  = (pulses == '0) || (bursts == '0);
  assign unlim_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      h_m1        <= '0;
      cfg_gap     <= '0;
      cfg_pulses  <= '0;
      unlimited   <= 1'b0;
      cnt         <= '0;
      pls_left    <= '0;
      brs_left    <= '0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      burst_done  <= 1'b0;
      done        <= 1'b0;
      pulse_count <= '0;
    end else begin
      burst_done <= 1'b0;
      done       <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        pulse_out <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              h_m1       <= hp_m1;
              cfg_gap    <= gap;
              cfg_pulses <= pulses;
              unlimited  <= unlim_req;
              if (zero_cfg) begin
                done <= 1'b1;
              end else begin
                state       <= HIGH;
                busy        <= 1'b1;
                pulse_out   <= 1'b1;
                pulse_count <= '0;
                cnt         <= hp_m1;
                pls_left    <= pulses - PULW'(1);
                brs_left    <= unlim_req ? '0 : bursts - BRSW'(1);
              end
            end
          end
          HIGH: begin
            if (cnt == '0) begin
              state     <= LOW;
              pulse_out <= 1'b0;
              cnt       <= h_m1;
            end else begin
              cnt <= cnt - CNTW'(1);
            end
          end
          LOW: begin
            if (cnt != '0) begin
              cnt <= cnt - CNTW'(1);
            end else begin
              pulse_count <= pulse_count + PULW'(1);
              if (pls_left != '0) begin
                pls_left  <= pls_left - PULW'(1);
                state     <= HIGH;
                pulse_out <= 1'b1;
                cnt       <= h_m1;
              end else if (unlimited || brs_left != '0) begin
                burst_done <= 1'b1;
                pls_left   <= cfg_pulses - PULW'(1);
                if (!unlimited) brs_left <= brs_left - BRSW'(1);
                // Zero gap chains straight into the next burst's first HIGH.
                if (cfg_gap != '0) begin
                  state <= GAP;
                  cnt   <= cfg_gap - CNTW'(1);
                end else begin
                  state       <= HIGH;
                  pulse_out   <= 1'b1;
                  cnt         <= h_m1;
                  pulse_count <= '0;
                end
              end else begin
                burst_done <= 1'b1;
                done       <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
              end
            end
          end
          GAP: begin
            if (cnt != '0) begin
              cnt <= cnt - CNTW'(1);
            end else begin
              state       <= HIGH;
              pulse_out   <= 1'b1;
              cnt         <= h_m1;
              pulse_count <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// Randomized bench: each run is compared cycle by cycle against a waveform
// built directly from the burst/pulse/gap arithmetic.
module tb_pulse_burst_sequencer;
  localparam int CNTW = 32;
  localparam int PULW = 16;
  localparam int BRSW = 8;
`ifdef PBS_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, start, abort;
  logic [CNTW-1:0] half_period, gap;
  logic [PULW-1:0] pulses;
  logic [BRSW-1:0] bursts;
  logic            pulse_out, busy, burst_done, done;
  logic [PULW-1:0] pulse_count;

  pulse_burst_sequencer #(.CNTW(CNTW), .PULW(PULW), .BRSW(BRSW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .half_period(half_period), .pulses(pulses), .bursts(bursts), .gap(gap),
    .pulse_out(pulse_out), .busy(busy), .burst_done(burst_done), .done(done),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  typedef logic [PULW+3:0] obs_t; // {pulse_out, busy, burst_done, done, pulse_count}
  obs_t            exp_q[$];
  int              n_chk = 0;
  int              n_fail = 0;
  logic [PULW-1:0] last_pc = '0;

  function automatic obs_t observed();
    return {pulse_out, busy, burst_done, done, pulse_count};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs, index 0 = cycle right after the start edge.
  task automatic build(input int h, input int p, input int b, input int g, input int cap);
    int  hh, nb;
    logic bd;
    hh = (h == 0) ? 1 : h;
    exp_q.delete();
    if (p == 0 || (b == 0 && !CONT)) begin
      exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, last_pc});
      return;
    end
    nb = (b == 0) ? cap : b;
    bd = 1'b0;
    for (int bi = 0; bi < nb; bi++) begin
      for (int pi = 0; pi < p; pi++)
        for (int k = 0; k < 2*hh; k++) begin
          exp_q.push_back({k < hh, 1'b1, bd, 1'b0, PULW'(pi)});
          bd = 1'b0;
        end
      if (bi < nb - 1) begin
        if (g > 0) begin
          for (int k = 0; k < g; k++) exp_q.push_back({1'b0, 1'b1, k == 0, 1'b0, PULW'(p)});
        end else begin
          bd = 1'b1;
        end
      end else begin
        exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, PULW'(p)});
      end
    end
  endtask

  // Called at a negedge in IDLE; ends at a negedge. ncmp limits how far the
  // waveform is compared; abort_at < 0 means run to completion.
  task automatic run(input string tag, input int h, input int p, input int b,
                     input int g, input int abort_at, input int cap, input int ncmp);
    int len;
    build(h, p, b, g, cap);
    len = (ncmp > 0 && ncmp < exp_q.size()) ? ncmp : exp_q.size();
    half_period = CNTW'(h); pulses = PULW'(p); bursts = BRSW'(b); gap = CNTW'(g);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk(tag, observed(), exp_q[i]);
      // Scramble config and poke start while busy: both must be ignored.
      half_period = CNTW'($urandom_range(0, 7)); pulses = PULW'($urandom_range(0, 7));
      bursts = BRSW'($urandom_range(0, 7)); gap = CNTW'($urandom_range(0, 7));
      start = (i + 1 < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == abort_at) begin
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk({tag, "_abort"}, observed(), {4'b0000, exp_q[i][PULW-1:0]});
        last_pc = exp_q[i][PULW-1:0];
        @(negedge clk);
        chk({tag, "_abort_idle"}, observed(), {4'b0000, last_pc});
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    last_pc = exp_q[exp_q.size()-1][PULW-1:0];
    if (len == exp_q.size()) chk({tag, "_idle"}, observed(), {4'b0000, last_pc});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    half_period = '0; pulses = '0; bursts = '0; gap = '0;
    #12;
    chk("reset_async", observed(), '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", observed(), '0);

    run("basic", 2, 3, 1, 0, -1, 0, 0);
    run("two_bursts", 1, 2, 2, 5, -1, 0, 0);
    run("hp_zero", 0, 4, 1, 0, -1, 0, 0);
    run("gap_zero", 1, 2, 3, 0, -1, 0, 0);
    run("abort_high", 10, 2, 1, 0, 2, 0, 0);
    run("after_abort", 2, 3, 1, 0, -1, 0, 0);
    run("zero_pulses", 3, 0, 2, 1, -1, 0, 0);
    run("max_pulses", 1, 300, 1, 0, -1, 0, 0);
    // Start and abort together in IDLE: no run, no strobe.
    start = 1'b1; abort = 1'b1; pulses = 16'd2; bursts = 8'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", observed(), {4'b0000, last_pc});
`ifdef PBS_CONTINUOUS_EN
    run("continuous", 1, 1, 0, 0, 608, 320, 0);
`else
    run("zero_bursts", 2, 3, 0, 1, -1, 0, 0);
`endif

    for (int r = 0; r < 40; r++) begin
      int h, p, b, g, a;
      h = $urandom_range(0, 3);
      p = $urandom_range(0, 4);
      b = CONT ? $urandom_range(1, 3) : $urandom_range(0, 3);
      g = $urandom_range(0, 4);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
      run("rand", h, p, b, g, a, 0, 0);
    end

    // Reset during the gap of a two-burst run.
    half_period = 32'd1; pulses = 16'd2; bursts = 8'd2; gap = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_gap", observed(), {1'b0, 1'b1, 1'b0, 1'b0, 16'd2});
    #2 reset = 1'b1;
    #1 chk("reset_mid_gap", observed(), '0);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("start_in_reset", observed(), '0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", observed(), '0);
    last_pc = '0;
    run("post_reset_run", 1, 2, 1, 0, -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pulse_burst_sequencer.md
# pulse_burst_sequencer

Controller that sequences the measurement pulse generator. On a start request it latches a half-period, a pulse count, a burst count and an inter-burst gap. It then drives a square-wave pulse train as a programmed number of bursts separated by idle gaps, and reports burst and run completion with one-cycle strobes. It sits between the board-level control (switches/host registers) and the GPIO pin that drives the measured target, replacing free-running divider/counter chains with a single programmable engine clocked directly from the 100 MHz system clock.

## Interface
- `CNTW`, default 32: width of the half-period and gap counters, in clk cycles.
- `PULW`, default 16: width of the pulse-per-burst count and `pulse_count`.
- `BRSW`, default 8: width of the burst count.

- `clk`  in  1  system clock (100 MHz); all logic on rising edge; one clock domain.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- `start`  in  1  run request; sampled only in IDLE.
- `abort`  in  1  terminate run; sampled every cycle.
- `half_period`  in  CNTW  high time and low time of each pulse, in cycles; 0 is treated as 1.
- `pulses`  in  PULW  pulses per burst.
- `bursts`  in  BRSW  number of bursts.
- `gap`  in  CNTW  low cycles between bursts.
- `pulse_out`  out  1  registered pulse train; reset 0.
- `busy`  out  1  high from start acceptance through the last low phase; reset 0.
- `burst_done`  out  1  one-cycle strobe at the end of each burst; reset 0.
- `done`  out  1  one-cycle strobe at the end of the run; reset 0.
- `pulse_count`  out  PULW  completed pulses in the current or last burst; reset 0.

## Operation
- States: IDLE, HIGH, LOW, GAP. All outputs are registered.
- IDLE, `start`=1, `abort`=0:
  - Latch all four config inputs; later input changes are ignored until the next start.
  - If `pulses`=0 or `bursts`=0 (see Configuration): pulse `done` for one cycle and stay in IDLE with `busy`=0.
  - Otherwise go to HIGH: `busy`=1, `pulse_out`=1, `pulse_count`=0, burst counter = `bursts`.
- HIGH: hold for H = max(half_period,1) cycles, then go to LOW with `pulse_out`=0.
- LOW: hold for H cycles. At the end, `pulse_count` increments. Then:
  - If pulses remain in the burst: go to HIGH.
  - Else, if bursts remain: assert `burst_done`. Go to GAP if `gap`>0, or straight to HIGH if `gap`=0; `pulse_count` clears on that HIGH entry.
  - Else: assert `burst_done` and `done` together, drop `busy`, go to IDLE.
- GAP: `pulse_out`=0 for `gap` cycles, then go to HIGH and clear `pulse_count`.
- `start` while busy is ignored.
- `abort`=1 in any non-IDLE state: next edge goes to IDLE with `pulse_out`=0 and `busy`=0. No `done` and no `burst_done` strobe. `pulse_count` holds its value.
- `start` and `abort` together in IDLE: abort wins; the block stays in IDLE with no strobes.
- All counters are down-counters loaded with value-1; they never wrap. Compares are on width-exact values; `pulses` up to 2^PULW-1 and `bursts` up to 2^BRSW-1 are legal.

## Timing
- Latency: `start` high before edge k gives `pulse_out`=1 and `busy`=1 after edge k.
- Each pulse is exactly H cycles high followed by H cycles low. No extra cycles between pulses, between a burst's last LOW and its GAP, or between a GAP and the next HIGH.
- Run length in cycles: bursts·pulses·2H + (bursts-1)·gap. `done` is high in the first cycle after the final low phase. Earliest restart is `start` in that same cycle, since the block is already in IDLE.
- `reset` asserted mid-run forces all outputs to their reset values asynchronously. After release the block sits in IDLE.

## Configuration
- `PBS_CONTINUOUS_EN` defined:
  - `bursts`=0 means unlimited bursts; the run ends only on `abort` or `reset`.
  - `done` never fires in this mode; `burst_done` fires every burst.
- Macro absent: `bursts`=0 completes immediately with a `done` strobe and no pulses.
- `pulses`=0 completes immediately in both builds.

## Test plan
- Basic run: half_period=2, pulses=3, bursts=1, gap=0, start at edge 0. Required:
  - `pulse_out` sequence 1,1,0,0 repeated three times.
  - `pulse_count` reaches 3.
  - `done` and `burst_done` high in cycle 12; `busy` low from cycle 12.
- Two bursts: half_period=1, pulses=2, bursts=2, gap=5. Required:
  - Two 4-cycle bursts separated by exactly 5 low cycles.
  - `burst_done` at cycles 4 and 13; `done` at cycle 13.
- Degenerate half-period: half_period=0, pulses=4, bursts=1. Required: identical to half_period=1, with `done` at cycle 8.
- Abort: abort in the 3rd cycle of HIGH (half_period=10). Required:
  - `pulse_out`=0 and `busy`=0 next cycle, with no strobes.
  - A new `start` is then accepted.
- Reset mid-GAP: required all outputs 0 immediately; `start` is ignored while `reset`=1.
- Zero bursts:
  - Without the macro: one `done` strobe, no pulses.
  - With `PBS_CONTINUOUS_EN`: bursts continue past 300 `burst_done` strobes until `abort`.
